// File: rtl/image_pkg.sv
// Shared definitions for the image staging buffer.
// Holds the config register map, the config bitfield layout and the engine state types.
// Optional feature macro: IMAGE_RD_REPEAT_EN (enables the CFG_IMG_RPT register).
package image_pkg;

    // Config register map
    localparam int unsigned CFG_IMG_WR  = 1;
    localparam int unsigned CFG_IMG_RD  = 2;
    localparam int unsigned CFG_IMG_RPT = 3;

    // Config payload bitfields: start address in the low half, count/length in the high half
    localparam int unsigned CFG_START_LSB = 0;
    localparam int unsigned CFG_LEN_LSB   = 16;
    localparam int unsigned CFG_FIELD_W   = 16;

    typedef enum logic {
        StWrIdle,
        StWrWrite
    } wr_state_e;

    typedef enum logic {
        StRdIdle,
        StRdRead
    } rd_state_e;

endpackage

// File: rtl/image_mem.sv
// Simple dual-port RAM for the image buffer.
// One write port and one read port on the same clock; read data is registered
// (1-cycle latency) and a same-address same-cycle access returns the old contents.
// Contents are not reset.
// Ports:
//   clk        clock
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read enable
//   rd_addr_i  read address
//   rd_data_o  registered read data
module image_mem #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    logic [DWIDTH-1:0] mem_q [0:(1 << AWIDTH) - 1];

    // Both ports in one block with non-blocking updates gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/image.sv
// Image staging buffer for the CNN coprocessor.
// A write engine unpacks stream words into RAM words; a read engine replays an
// address range to the compute array, GROUP_NB pixels per beat, through an output
// register backed by a 2-entry skid buffer.
// Optional feature macro: IMAGE_RD_REPEAT_EN (CFG_IMG_RPT register, multi-pass reads).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_data/addr/valid   config bus write
//   str_img_bus/val/rdy   input image stream
//   image_bus/last/val    output beats (pixel 0 in LSBs)
//   image_rdy             output ready
module image #(
    parameter int unsigned CFG_DWIDTH    = 32,
    parameter int unsigned CFG_AWIDTH    = 5,
    parameter int unsigned STR_IMG_WIDTH = 64,
    parameter int unsigned GROUP_NB      = 4,
    parameter int unsigned IMG_WIDTH     = 16,
    parameter int unsigned DEPTH_NB      = 1,
    parameter int unsigned MEM_AWIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [STR_IMG_WIDTH-1:0]      str_img_bus,
    input  logic                          str_img_val,
    output logic                          str_img_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_last,
    output logic                          image_val,
    input  logic                          image_rdy
);

    import image_pkg::*;

    localparam int unsigned RAM_DW  = GROUP_NB * IMG_WIDTH;
    localparam int unsigned SLICE_W = (DEPTH_NB > 1) ? $clog2(DEPTH_NB) : 1;

    // Config decode
    logic                   cfg_wr, cfg_rd;
    logic [MEM_AWIDTH-1:0]  cfg_start;
    logic [CFG_FIELD_W-1:0] cfg_len;

    assign cfg_wr    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IMG_WR));
    assign cfg_rd    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IMG_RD));
    assign cfg_start = cfg_data[CFG_START_LSB +: MEM_AWIDTH];
    assign cfg_len   = cfg_data[CFG_LEN_LSB +: CFG_FIELD_W];

    logic unused_cfg;
    assign unused_cfg = ^cfg_data[CFG_FIELD_W-1:MEM_AWIDTH];

    // RAM
    logic                  mem_we, mem_re;
    logic [MEM_AWIDTH-1:0] mem_waddr, mem_raddr;
    logic [RAM_DW-1:0]     mem_wdata, mem_rdata;

    image_mem #(
        .DWIDTH (RAM_DW),
        .AWIDTH (MEM_AWIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_we),
        .wr_addr_i (mem_waddr),
        .wr_data_i (mem_wdata),
        .rd_en_i   (mem_re),
        .rd_addr_i (mem_raddr),
        .rd_data_o (mem_rdata)
    );

    // ---------------------------------------------------------------- write engine
    wr_state_e              wr_state_q, wr_state_d;
    logic [MEM_AWIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [CFG_FIELD_W-1:0] wr_cnt_q, wr_cnt_d;
    logic                   wr_pend_q, wr_pend_d;
    logic [SLICE_W-1:0]     wr_slice_q, wr_slice_d;
    logic [STR_IMG_WIDTH-1:0] wr_word_q, wr_word_d;
    logic                   str_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= StWrIdle;
            wr_addr_q  <= '0;
            wr_cnt_q   <= '0;
            wr_pend_q  <= 1'b0;
            wr_slice_q <= '0;
            wr_word_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_pend_q  <= wr_pend_d;
            wr_slice_q <= wr_slice_d;
            wr_word_q  <= wr_word_d;
        end
    end

    assign str_img_rdy = (wr_state_q == StWrWrite) && !wr_pend_q;
    assign str_xfer    = str_img_val && str_img_rdy;
    assign mem_waddr   = wr_addr_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_cnt_d   = wr_cnt_q;
        wr_pend_d  = wr_pend_q;
        wr_slice_d = wr_slice_q;
        wr_word_d  = wr_word_q;
        mem_we     = 1'b0;
        mem_wdata  = str_img_bus[RAM_DW-1:0];
        case (wr_state_q)
            StWrIdle: begin
                if (cfg_wr && (cfg_len != '0)) begin
                    wr_state_d = StWrWrite;
                    wr_addr_d  = cfg_start;
                    wr_cnt_d   = cfg_len;
                end
            end
            StWrWrite: begin
                if (str_xfer || wr_pend_q) begin
                    mem_we    = 1'b1;
                    // Slice 0 goes straight from the bus; later slices from the held word
                    if (wr_pend_q) begin
                        mem_wdata = wr_word_q[int'(wr_slice_q)*RAM_DW +: RAM_DW];
                    end
                    wr_addr_d = wr_addr_q + MEM_AWIDTH'(1);
                    wr_cnt_d  = wr_cnt_q - CFG_FIELD_W'(1);
                    if (wr_cnt_q == CFG_FIELD_W'(1)) begin
                        // Count exhausted: a partially used stream word is dropped here
                        wr_state_d = StWrIdle;
                        wr_pend_d  = 1'b0;
                        wr_slice_d = '0;
                    end else if (wr_pend_q) begin
                        if (wr_slice_q == SLICE_W'(DEPTH_NB - 1)) begin
                            wr_pend_d  = 1'b0;
                            wr_slice_d = '0;
                        end else begin
                            wr_slice_d = wr_slice_q + SLICE_W'(1);
                        end
                    end else if (DEPTH_NB > 1) begin
                        wr_pend_d  = 1'b1;
                        wr_slice_d = SLICE_W'(1);
                        wr_word_d  = str_img_bus;
                    end
                end
            end
            default: wr_state_d = StWrIdle;
        endcase
    end

    // ---------------------------------------------------------------- read engine
    rd_state_e              rd_state_q, rd_state_d;
    logic [MEM_AWIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [MEM_AWIDTH-1:0]  rd_start_q, rd_start_d;
    logic [CFG_FIELD_W-1:0] rd_len_q, rd_len_d;
    logic [CFG_FIELD_W-1:0] rd_left_q, rd_left_d;
    logic [CFG_FIELD_W-1:0] rpt_left_q, rpt_left_d;
    logic                   inflight_q, inflight_last_q;
    logic                   issue, issue_last;
    logic [2:0]             occ;

    // Output register and skid buffer (entry 0 is the oldest)
    logic                   out_val_q, out_val_d;
    logic                   out_last_q, out_last_d;
    logic [RAM_DW-1:0]      out_data_q, out_data_d;
    logic [1:0][RAM_DW-1:0] skid_data_q, skid_data_d;
    logic [1:0]             skid_last_q, skid_last_d;
    logic [1:0]             skid_cnt_q, skid_cnt_d;
    logic                   pop, out_free;

`ifdef IMAGE_RD_REPEAT_EN
    logic [CFG_FIELD_W-1:0] rpt_cfg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cfg_q <= '0;
        end else if (cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IMG_RPT))) begin
            rpt_cfg_q <= cfg_data[CFG_START_LSB +: CFG_FIELD_W];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q      <= StRdIdle;
            rd_addr_q       <= '0;
            rd_start_q      <= '0;
            rd_len_q        <= '0;
            rd_left_q       <= '0;
            rpt_left_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            out_val_q       <= 1'b0;
            out_last_q      <= 1'b0;
            out_data_q      <= '0;
            skid_data_q     <= '0;
            skid_last_q     <= '0;
            skid_cnt_q      <= '0;
        end else begin
            rd_state_q      <= rd_state_d;
            rd_addr_q       <= rd_addr_d;
            rd_start_q      <= rd_start_d;
            rd_len_q        <= rd_len_d;
            rd_left_q       <= rd_left_d;
            rpt_left_q      <= rpt_left_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            out_val_q       <= out_val_d;
            out_last_q      <= out_last_d;
            out_data_q      <= out_data_d;
            skid_data_q     <= skid_data_d;
            skid_last_q     <= skid_last_d;
            skid_cnt_q      <= skid_cnt_d;
        end
    end

    // Only issue a read when every possible in-flight beat has a slot to land in.
    assign occ        = {2'b0, out_val_q} + {1'b0, skid_cnt_q} + {2'b0, inflight_q};
    assign issue      = (rd_state_q == StRdRead) && (rd_left_q != '0) && (occ < 3'd3);
    assign issue_last = issue && (rd_left_q == CFG_FIELD_W'(1)) && (rpt_left_q == '0);
    assign mem_re     = issue;
    assign mem_raddr  = rd_addr_q;
    assign pop        = out_val_q && image_rdy;
    assign out_free   = !out_val_q || image_rdy;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_start_d = rd_start_q;
        rd_len_d   = rd_len_q;
        rd_left_d  = rd_left_q;
        rpt_left_d = rpt_left_q;
        case (rd_state_q)
            StRdIdle: begin
                if (cfg_rd && (cfg_len != '0)) begin
                    rd_state_d = StRdRead;
                    rd_addr_d  = cfg_start;
                    rd_start_d = cfg_start;
                    rd_len_d   = cfg_len;
                    rd_left_d  = cfg_len;
`ifdef IMAGE_RD_REPEAT_EN
                    rpt_left_d = rpt_cfg_q;
`else
                    rpt_left_d = '0;
`endif
                end
            end
            StRdRead: begin
                if (issue) begin
                    if ((rd_left_q == CFG_FIELD_W'(1)) && (rpt_left_q != '0)) begin
                        // Restart the range immediately so passes run back-to-back
                        rd_addr_d  = rd_start_q;
                        rd_left_d  = rd_len_q;
                        rpt_left_d = rpt_left_q - CFG_FIELD_W'(1);
                    end else begin
                        rd_addr_d  = rd_addr_q + MEM_AWIDTH'(1);
                        rd_left_d  = rd_left_q - CFG_FIELD_W'(1);
                    end
                end
                if (pop && out_last_q) begin
                    rd_state_d = StRdIdle;
                end
            end
            default: rd_state_d = StRdIdle;
        endcase
    end

    always_comb begin
        out_val_d   = out_val_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_cnt_d  = skid_cnt_q;
        if (out_free) begin
            if (skid_cnt_q != 2'd0) begin
                out_val_d      = 1'b1;
                out_data_d     = skid_data_q[0];
                out_last_d     = skid_last_q[0];
                skid_data_d[0] = skid_data_q[1];
                skid_last_d[0] = skid_last_q[1];
                skid_cnt_d     = skid_cnt_q - 2'd1;
            end else if (inflight_q) begin
                out_val_d  = 1'b1;
                out_data_d = mem_rdata;
                out_last_d = inflight_last_q;
            end else begin
                out_val_d  = 1'b0;
                out_last_d = 1'b0;
            end
        end
        // RAM data is only valid for one cycle, so park it if it didn't go to the output
        if (inflight_q && !(out_free && (skid_cnt_q == 2'd0))) begin
            skid_data_d[skid_cnt_d[0]] = mem_rdata;
            skid_last_d[skid_cnt_d[0]] = inflight_last_q;
            skid_cnt_d                 = skid_cnt_d + 2'd1;
        end
    end

    assign image_val  = out_val_q;
    assign image_last = out_last_q;
    assign image_bus  = out_data_q;

endmodule

// File: tb/tb_image.sv
module tb_image;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic [63:0] str_img_bus;
    logic        str_img_val;
    logic        str_img_rdy;
    logic [63:0] image_bus;
    logic        image_last;
    logic        image_val;
    logic        image_rdy;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q [0:15];

    localparam logic [63:0] W0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] W1 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] W2 = 64'h000c_000b_000a_0009;
    localparam logic [63:0] W3 = 64'h0010_000f_000e_000d;
    localparam logic [63:0] WA = 64'hA0A1_A2A3_A4A5_A6A7;
    localparam logic [63:0] WB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [63:0] WC = 64'hC0C1_C2C3_C4C5_C6C7;
    localparam logic [63:0] WD = 64'hD0D1_D2D3_D4D5_D6D7;

    image u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_data    (cfg_data),
        .cfg_addr    (cfg_addr),
        .cfg_valid   (cfg_valid),
        .str_img_bus (str_img_bus),
        .str_img_val (str_img_val),
        .str_img_rdy (str_img_rdy),
        .image_bus   (image_bus),
        .image_last  (image_last),
        .image_val   (image_val),
        .image_rdy   (image_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [4:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
    endtask

    // Streams exp_q[0..n-1] into the write engine.
    task automatic stream(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            int c;
            c = 0;
            str_img_bus = exp_q[i];
            str_img_val = 1'b1;
            while (!str_img_rdy && c < 20) begin
                tick;
                c++;
            end
            if (c >= 20) chk({tag, " rdy timeout"}, 64'(str_img_rdy), 64'd1);
            tick;
        end
        str_img_val = 1'b0;
        str_img_bus = '0;
        chk({tag, " rdy low after count"}, 64'(str_img_rdy), 64'd0);
    endtask

    // Accepts n beats, comparing with exp_q; optional 1,0,0,1 ready pattern.
    task automatic collect(input string tag, input int n, input bit stall);
        int k;
        int c;
        bit was_stalled;
        logic [63:0] held;
        logic held_last;
        k = 0;
        c = 0;
        was_stalled = 1'b0;
        held = '0;
        held_last = 1'b0;
        while (k < n && c < 200) begin
            image_rdy = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (was_stalled) begin
                chk({tag, " hold val"}, 64'(image_val), 64'd1);
                chk({tag, " hold bus"}, image_bus, held);
                chk({tag, " hold last"}, 64'(image_last), 64'(held_last));
            end
            if (!stall && k > 0) chk({tag, " no bubble"}, 64'(image_val), 64'd1);
            was_stalled = 1'b0;
            if (image_val) begin
                if (image_rdy) begin
                    chk({tag, " bus"}, image_bus, exp_q[k]);
                    chk({tag, " last"}, 64'(image_last), 64'(k == n - 1));
                    k++;
                end else begin
                    held = image_bus;
                    held_last = image_last;
                    was_stalled = 1'b1;
                end
            end
            tick;
            c++;
        end
        chk({tag, " beat count"}, 64'(k), 64'(n));
        image_rdy = 1'b1;
        repeat (4) begin
            chk({tag, " idle after"}, 64'(image_val), 64'd0);
            tick;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_data = '0;
        cfg_addr = '0;
        cfg_valid = 1'b0;
        str_img_bus = '0;
        str_img_val = 1'b0;
        image_rdy = 1'b1;
        repeat (6) tick;
        rst = 1'b0;

        // Reset state
        chk("reset rdy", 64'(str_img_rdy), 64'd0);
        chk("reset val", 64'(image_val), 64'd0);
        chk("reset last", 64'(image_last), 64'd0);
        chk("reset bus", image_bus, 64'd0);

        // Unknown address ignored
        cfg(5'd0, 32'h0004_0000);
        chk("addr0 rdy", 64'(str_img_rdy), 64'd0);
        tick;
        tick;
        chk("addr0 val", 64'(image_val), 64'd0);

        // Write 4 words at 0x00
        cfg(5'd1, 32'h0004_0000);
        chk("wr4 rdy high", 64'(str_img_rdy), 64'd1);
        exp_q[0] = W0; exp_q[1] = W1; exp_q[2] = W2; exp_q[3] = W3;
        stream("wr4", 4);

        // Read them back, checking latency
        cfg(5'd2, 32'h0004_0000);
        chk("rd4 val N", 64'(image_val), 64'd0);
        tick;
        chk("rd4 val N+1", 64'(image_val), 64'd0);
        tick;
        chk("rd4 val N+2", 64'(image_val), 64'd1);
        collect("rd4", 4, 1'b0);

        // Length 3 under back-pressure
        exp_q[0] = W1; exp_q[1] = W2; exp_q[2] = W3;
        cfg(5'd2, 32'h0003_0001);
        collect("rd3 stall", 3, 1'b1);

        // Wrap across the top of the address space
        exp_q[0] = WA; exp_q[1] = WB;
        cfg(5'd1, 32'h0002_00FF);
        stream("wrwrap", 2);
        cfg(5'd2, 32'h0002_00FF);
        collect("rdwrap", 2, 1'b0);

        // Second read config while busy is ignored
        exp_q[0] = W1; exp_q[1] = W2; exp_q[2] = W3;
        cfg(5'd2, 32'h0003_0001);
        cfg(5'd2, 32'h0005_00FF);
        tick;
        chk("busy rd val", 64'(image_val), 64'd1);
        collect("busy rd", 3, 1'b0);

        // Reset mid-read
        cfg(5'd2, 32'h0004_0000);
        image_rdy = 1'b0;
        tick;
        tick;
        chk("midrst val before", 64'(image_val), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst val", 64'(image_val), 64'd0);
        chk("midrst last", 64'(image_last), 64'd0);
        chk("midrst bus", image_bus, 64'd0);
        chk("midrst str rdy", 64'(str_img_rdy), 64'd0);
        image_rdy = 1'b1;
        repeat (4) begin
            chk("midrst stays idle", 64'(image_val), 64'd0);
            tick;
        end

        // RAM survives reset
        exp_q[0] = WA; exp_q[1] = WB;
        cfg(5'd2, 32'h0002_00FF);
        collect("post rst rd", 2, 1'b0);

        // Repeat register (ignored unless the feature is built in)
        cfg(5'd3, 32'h0000_0002);
        exp_q[0] = WC; exp_q[1] = WD;
        cfg(5'd1, 32'h0002_0010);
        stream("wr10", 2);
`ifdef IMAGE_RD_REPEAT_EN
        for (int i = 0; i < 6; i++) exp_q[i] = (i % 2 == 0) ? WC : WD;
        cfg(5'd2, 32'h0002_0010);
        collect("rpt rd", 6, 1'b0);
`else
        cfg(5'd2, 32'h0002_0010);
        collect("rpt ignored rd", 2, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
